// File: rtl/aes_reg_bank.sv
// rtl/aes_reg_bank.sv - AES working registers r0..r3 with busC write-back and word-serial host load
// Host words gather in a shadow buffer and are committed to the target register in one edge.
module aes_reg_bank #(
    parameter int WORD_W = 32,
    parameter int DATA_W = 128,
    parameter int R3_W   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    input  logic [1:0]        host_wr_sel,
    input  logic [WORD_W-1:0] host_wr_data,
    input  logic              host_wr_abort,
    output logic              load_done,
    input  logic [DATA_W-1:0] busC,
    input  logic [1:0]        SEL_busC,
    input  logic              WE_busC,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [R3_W-1:0]   r3
);

    localparam int OFS_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        tgt;
    logic [1:0]        count;
    logic [DATA_W-1:0] shadow;

    logic              accept;
    logic              last_word;
    logic              commit;
    logic [1:0]        word_tgt;
    logic [1:0]        word_idx;
    logic [OFS_W-1:0]  word_lo;

    always_comb begin
        state_nxt     = state;
        host_wr_ready = 1'b0;
        commit        = 1'b0;
        accept        = 1'b0;
        // In IDLE the incoming word is word 0 of a load aimed at host_wr_sel
        word_tgt  = (state == ST_IDLE) ? host_wr_sel : tgt;
        word_idx  = (state == ST_IDLE) ? 2'd0 : count;
        last_word = (word_tgt == 2'd3) ? (word_idx == 2'd1) : (word_idx == 2'd3);
        word_lo   = ((word_tgt == 2'd3) ? OFS_W'(R3_W - WORD_W) : OFS_W'(DATA_W - WORD_W))
                    - OFS_W'(int'(word_idx) * WORD_W);

        case (state)
            ST_IDLE: begin
                // Holding off during the done pulse keeps it clear of the next load's first word
                host_wr_ready = !host_wr_abort && !load_done;
                accept        = host_wr_valid && host_wr_ready;
                if (accept) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (host_wr_abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    host_wr_ready = 1'b1;
                    accept        = host_wr_valid;
                    if (accept && last_word) begin
                        state_nxt = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                // A write-back to the same register wins; the commit retries next cycle
                commit = !(WE_busC && (SEL_busC == tgt));
                if (commit) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tgt       <= 2'd0;
            count     <= 2'd0;
            shadow    <= '0;
            load_done <= 1'b0;
            r0        <= '0;
            r1        <= '0;
            r2        <= '0;
            r3        <= '0;
        end else begin
            state     <= state_nxt;
            load_done <= commit;

            if (accept) begin
                if (state == ST_IDLE) begin
                    tgt    <= host_wr_sel;
                    count  <= 2'd1;
                    shadow <= '0;
                end else if (!last_word) begin
                    count <= count + 2'd1;
                end
                shadow[word_lo +: WORD_W] <= host_wr_data;
            end

            if (state == ST_LOAD && host_wr_abort) begin
                count <= 2'd0;
            end

            if (commit) begin
                count <= 2'd0;
                case (tgt)
                    2'd0:    r0 <= shadow;
                    2'd1:    r1 <= shadow;
                    2'd2:    r2 <= shadow;
                    default: r3 <= shadow[R3_W-1:0];
                endcase
            end

            if (WE_busC) begin
                case (SEL_busC)
                    2'd0:    r0 <= busC;
                    2'd1:    r1 <= busC;
                    2'd2:    r2 <= busC;
                    default: r3 <= busC[R3_W-1:0];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_reg_bank.sv
// tb/tb_aes_reg_bank.sv - directed and randomized bench for aes_reg_bank against a queue-based model
module tb_aes_reg_bank;

    logic         clk;
    logic         rst;
    logic         host_wr_valid;
    logic         host_wr_ready;
    logic [1:0]   host_wr_sel;
    logic [31:0]  host_wr_data;
    logic         host_wr_abort;
    logic         load_done;
    logic [127:0] busC;
    logic [1:0]   SEL_busC;
    logic         WE_busC;
    logic [127:0] r0;
    logic [127:0] r1;
    logic [127:0] r2;
    logic [63:0]  r3;

    aes_reg_bank dut (
        .clk           (clk),
        .rst           (rst),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_sel   (host_wr_sel),
        .host_wr_data  (host_wr_data),
        .host_wr_abort (host_wr_abort),
        .load_done     (load_done),
        .busC          (busC),
        .SEL_busC      (SEL_busC),
        .WE_busC       (WE_busC),
        .r0            (r0),
        .r1            (r1),
        .r2            (r2),
        .r3            (r3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: register contents, the words of the load in progress, and pending flags
    logic [127:0] m_r [4];
    logic [31:0]  m_q [$];
    logic [1:0]   m_tgt;
    bit           m_commit;
    bit           m_done;
    bit           m_init;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int words_needed(input logic [1:0] t);
        return (t == 2'd3) ? 2 : 4;
    endfunction

    function automatic logic [127:0] assemble();
        logic [127:0] v = '0;
        foreach (m_q[i]) v = (v << 32) | {96'b0, m_q[i]};
        return v;
    endfunction

    function automatic bit model_ready(input bit ab);
        if (m_commit) return 1'b0;
        if (ab) return 1'b0;
        if (m_q.size() == 0 && m_done) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input bit v, input logic [1:0] s, input logic [31:0] d, input bit ab,
                              input bit we, input logic [1:0] ws, input logic [127:0] bc,
                              input bit r, input bit rdy);
        bit nd = 1'b0;
        if (r) begin
            foreach (m_r[i]) m_r[i] = '0;
            m_q.delete();
            m_commit = 1'b0;
            m_done   = 1'b0;
            m_init   = 1'b1;
            return;
        end
        if (m_commit) begin
            if (!(we && ws == m_tgt)) begin
                m_r[m_tgt] = assemble();
                m_q.delete();
                m_commit = 1'b0;
                nd = 1'b1;
            end
        end else if (m_q.size() > 0 && ab) begin
            m_q.delete();
        end else if (v && rdy) begin
            if (m_q.size() == 0) m_tgt = s;
            m_q.push_back(d);
            if (m_q.size() == words_needed(m_tgt)) m_commit = 1'b1;
        end
        if (we) m_r[ws] = (ws == 2'd3) ? {64'b0, bc[63:0]} : bc;
        m_done = nd;
    endtask

    // One clock: drive, check ready mid-cycle, advance model at the edge, check registers after it
    task automatic step(input bit v, input logic [1:0] s, input logic [31:0] d, input bit ab,
                        input bit we, input logic [1:0] ws, input logic [127:0] bc, input bit r);
        bit rdy;
        host_wr_valid = v;
        host_wr_sel   = s;
        host_wr_data  = d;
        host_wr_abort = ab;
        WE_busC       = we;
        SEL_busC      = ws;
        busC          = bc;
        rst           = r;
        @(negedge clk);
        rdy = model_ready(ab);
        if (m_init) chk("ready", {127'b0, host_wr_ready}, {127'b0, rdy});
        @(posedge clk);
        model_step(v, s, d, ab, we, ws, bc, r, rdy);
        #1;
        if (m_init) begin
            chk("r0", r0, m_r[0]);
            chk("r1", r1, m_r[1]);
            chk("r2", r2, m_r[2]);
            chk("r3", {64'b0, r3}, {64'b0, m_r[3][63:0]});
            chk("load_done", {127'b0, load_done}, {127'b0, m_done});
        end
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 2'd0, 128'h0, 1'b0);
    endtask

    task automatic host_word(input logic [1:0] s, input logic [31:0] d);
        step(1'b1, s, d, 1'b0, 1'b0, 2'd0, 128'h0, 1'b0);
    endtask

    logic [31:0]  w_r0 [4];
    logic [127:0] saved_r0;

    initial begin
        m_init = 1'b0;
        m_commit = 1'b0;
        m_done = 1'b0;
        m_tgt = 2'd0;
        foreach (m_r[i]) m_r[i] = '0;
        rst = 1'b1;
        host_wr_valid = 1'b0;
        host_wr_sel = 2'd0;
        host_wr_data = '0;
        host_wr_abort = 1'b0;
        WE_busC = 1'b0;
        SEL_busC = 2'd0;
        busC = '0;
        w_r0[0] = 32'h00112233;
        w_r0[1] = 32'h44556677;
        w_r0[2] = 32'h8899AABB;
        w_r0[3] = 32'hCCDDEEFF;
        @(posedge clk);
        #1;

        step(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 2'd0, 128'h0, 1'b1);
        step(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 2'd0, 128'h0, 1'b1);
        chk("reset_r0", r0, 128'h0);
        chk("reset_r3", {64'b0, r3}, 128'h0);
        idle();
        chk("reset_ready", {127'b0, host_wr_ready}, 128'h1);

        for (int k = 0; k < 4; k++) host_word(2'd0, w_r0[k]);
        chk("commit_ready", {127'b0, host_wr_ready}, 128'h0);
        idle();
        chk("plan_r0", r0, 128'h00112233445566778899AABBCCDDEEFF);
        chk("plan_r0_done", {127'b0, load_done}, 128'h1);
        idle();
        chk("plan_r0_done_once", {127'b0, load_done}, 128'h0);

        host_word(2'd3, 32'hDEADBEEF);
        host_word(2'd3, 32'h01234567);
        idle();
        chk("plan_r3", {64'b0, r3}, {64'b0, 64'hDEADBEEF01234567});
        chk("plan_r3_r0_kept", r0, 128'h00112233445566778899AABBCCDDEEFF);
        idle();

        step(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 2'd2, {128{1'b1}}, 1'b0);
        chk("plan_wb_r2", r2, {128{1'b1}});
        step(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 2'd3, {{64{4'hA}}, {64{4'h5}}} >> 0, 1'b0);
        chk("plan_wb_r3", {64'b0, r3}, {64'b0, 64'h5555555555555555});

        for (int k = 0; k < 4; k++) host_word(2'd1, 32'h10000000 + k);
        step(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 2'd1, 128'hC0111DE_0001, 1'b0);
        chk("coll_r1_busc1", r1, 128'hC0111DE_0001);
        chk("coll_done_hold1", {127'b0, load_done}, 128'h0);
        step(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 2'd1, 128'hC0111DE_0002, 1'b0);
        chk("coll_r1_busc2", r1, 128'hC0111DE_0002);
        chk("coll_done_hold2", {127'b0, load_done}, 128'h0);
        idle();
        chk("coll_r1_host", r1, 128'h10000000100000011000000210000003);
        chk("coll_done", {127'b0, load_done}, 128'h1);
        idle();

        saved_r0 = r0;
        host_word(2'd0, 32'hAAAA0000);
        host_word(2'd0, 32'hAAAA0001);
        step(1'b1, 2'd0, 32'hAAAA0002, 1'b1, 1'b0, 2'd0, 128'h0, 1'b0);
        idle();
        chk("abort_r0_kept", r0, saved_r0);
        chk("abort_no_done", {127'b0, load_done}, 128'h0);
        for (int k = 0; k < 4; k++) host_word(2'd0, w_r0[3-k]);
        idle();
        chk("post_abort_r0", r0, 128'hCCDDEEFF8899AABB4455667700112233);
        idle();

        for (int k = 0; k < 3; k++) host_word(2'd0, w_r0[k]);
        step(1'b1, 2'd0, w_r0[3], 1'b0, 1'b0, 2'd0, 128'h0, 1'b1);
        chk("midrst_r0", r0, 128'h0);
        chk("midrst_r1", r1, 128'h0);
        idle();
        chk("midrst_idle_ready", {127'b0, host_wr_ready}, 128'h1);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) < 7, 2'($urandom), $urandom, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) == 0, 2'($urandom),
                 {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
